// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types and constants (multiplier FSM states, widths, Booth select codes)
package alu_pkg;
  localparam int WIDTH = 8;
  localparam int ITER  = 8;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mlcla.sv
// mlcla: 8-bit two-level carry-lookahead adder (two 4-bit groups plus group lookahead)
// ports: x, y = addends; c0 = carry-in; sum = x+y+c0 (8 bits); c8 = carry-out
module mlcla
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c0,
  output logic [WIDTH-1:0] sum,
  output logic             c8
);
  logic [7:0] w_g, w_p, w_c;
  logic [1:0] w_gg, w_gp, w_cin;
  assign w_g = x & y;
  assign w_p = x ^ y;
  assign w_cin[0] = c0;
  assign w_cin[1] = w_gg[0] | (w_gp[0] & c0);
  assign c8 = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & c0);
  for (genvar k = 0; k < 2; k++) begin : g_grp
    logic [3:0] w_gk, w_pk;
    assign w_gk = w_g[4*k +: 4];
    assign w_pk = w_p[4*k +: 4];
    assign w_gg[k] = w_gk[3] | (w_pk[3] & w_gk[2]) | (w_pk[3] & w_pk[2] & w_gk[1])
                   | (w_pk[3] & w_pk[2] & w_pk[1] & w_gk[0]);
    assign w_gp[k] = &w_pk;
    assign w_c[4*k]   = w_cin[k];
    assign w_c[4*k+1] = w_gk[0] | (w_pk[0] & w_cin[k]);
    assign w_c[4*k+2] = w_gk[1] | (w_pk[1] & w_gk[0]) | (w_pk[1] & w_pk[0] & w_cin[k]);
    assign w_c[4*k+3] = w_gk[2] | (w_pk[2] & w_gk[1]) | (w_pk[2] & w_pk[1] & w_gk[0])
                      | (w_pk[2] & w_pk[1] & w_pk[0] & w_cin[k]);
  end
  assign sum = w_p ^ w_c;
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth 8x8 signed multiplier using mlcla as its adder
// ports: clk, rst (async, active-high); start/a/b = request and operands;
//        busy = iterating; done = one-cycle result pulse; product = signed {A,Q}
// option: MUL_ZERO_SKIP_EN finishes immediately with product 0 when an operand is zero
module booth_mul_seq
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   a,
  input  logic [7:0]   b,
  output logic         busy,
  output logic         done,
  output logic [15:0]  product
);
  state_t      r_state, w_next;
  logic [7:0]  r_a, r_q, r_m;
  logic        r_q1;
  logic [3:0]  r_count;
  logic [15:0] r_product;
  logic [1:0]  w_sel;
  logic        w_add, w_sub, w_act, w_ovf, w_sign, w_last, w_zero, w_unused_c8;
  logic [7:0]  w_y, w_s, w_sum, w_a_nx, w_q_nx;
  assign w_sel = {r_q[0], r_q1};
  assign w_add = w_sel == BOOTH_ADD;
  assign w_sub = w_sel == BOOTH_SUB;
  assign w_act = w_add | w_sub;
  assign w_y   = w_sub ? ~r_m : r_m;
  mlcla u_add (.x(r_a), .y(w_y), .c0(w_sub), .sum(w_s), .c8(w_unused_c8));
  assign w_sum = w_act ? w_s : r_a;
  // A is only 8 bits, so the sign shifted in must be the true 9-bit sign of the sum
  assign w_ovf  = w_act && (r_a[7] == w_y[7]) && (w_s[7] != r_a[7]);
  assign w_sign = w_ovf ? ~w_sum[7] : w_sum[7];
  assign w_a_nx = {w_sign, w_sum[7:1]};
  assign w_q_nx = {w_sum[0], r_q[7:1]};
  assign w_last = r_count == 4'(ITER - 1);
`ifdef MUL_ZERO_SKIP_EN
  assign w_zero = (a == '0) || (b == '0);
`else
  assign w_zero = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (w_zero ? DONE : RUN) : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy = r_state == RUN;
    done = r_state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_q1      <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else if (r_state == IDLE && start) begin
      r_m     <= a;
      r_q     <= b;
      r_a     <= '0;
      r_q1    <= 1'b0;
      r_count <= '0;
      if (w_zero) r_product <= '0;
    end else if (r_state == RUN) begin
      r_a     <= w_a_nx;
      r_q     <= w_q_nx;
      r_q1    <= r_q[0];
      r_count <= r_count + 4'd1;
      if (w_last) r_product <= {w_a_nx, w_q_nx};
    end
  assign product = r_product;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed self-checking bench for booth_mul_seq
module tb_booth_mul_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy, done;
  logic [15:0] product;
  int n_checks = 0;
  int n_fail = 0;

  booth_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int cyc, output int bsy);
    cyc = 1;
    bsy = 0;
    while (!done && cyc < 40) begin
      bsy += int'(busy);
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done), 1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] exp, input int exp_lat, input int exp_busy);
    int cyc, bsy;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ia;
    b = ~ib;
    wait_done(cyc, bsy);
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bsy), 32'(exp_busy));
    check({tag, "_prod"}, 32'(product), 32'(exp));
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done), 0);
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int cyc, bsy, seen;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_prod", 32'(product), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("3x4", 8'd3, 8'd4, 16'h000C, 9, 8);
    run_op("m128xm128", 8'h80, 8'h80, 16'h4000, 9, 8);
    run_op("m128x127", 8'h80, 8'h7F, 16'hC080, 9, 8);
    run_op("127xm1", 8'h7F, 8'hFF, 16'hFF81, 9, 8);
    run_op("m1xm1", 8'hFF, 8'hFF, 16'h0001, 9, 8);
    run_op("127x127", 8'h7F, 8'h7F, 16'h3F01, 9, 8);
`ifdef MUL_ZERO_SKIP_EN
    run_op("0x55", 8'h00, 8'h55, 16'h0000, 1, 0);
`else
    run_op("0x55", 8'h00, 8'h55, 16'h0000, 9, 8);
`endif

    // start held high through RUN/DONE with new operands
    @(negedge clk);
    a = 8'd6;
    b = 8'd7;
    start = 1'b1;
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    wait_done(cyc, bsy);
    check("hold_first_prod", 32'(product), 32'h002A);
    check("hold_first_lat", 32'(cyc), 9);
    @(negedge clk);
    check("hold_idle_busy", 32'(busy), 0);
    check("hold_idle_done", 32'(done), 0);
    @(negedge clk);
    check("hold_restart_busy", 32'(busy), 1);
    start = 1'b0;
    wait_done(cyc, bsy);
    check("hold_second_prod", 32'(product), 32'h4000);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    a = 8'd3;
    b = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_pre", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_prod", 32'(product), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= int'(done);
    end
    check("mid_rst_no_done", 32'(seen), 0);
    run_op("5xm6", 8'd5, 8'hFA, 16'hFFE2, 9, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
